// File: rtl/shift_pipe.sv
// Four-stage registered barrel shifter (rotate/logical, left/right) with a global-stall valid/ready pipe.
// Define SHIFT_PIPE_FLAGS_EN to add the registered zero and cout result flags.
module shift_pipe #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WIDTH-1:0]  In,
   input  logic [1:0]        Op,
   input  logic [STAGES-1:0] Cnt,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              flush,
   output logic [WIDTH-1:0]  Out,
   output logic              out_valid,
   input  logic              out_ready
`ifdef SHIFT_PIPE_FLAGS_EN
   ,
   output logic              zero,
   output logic              cout
`endif
);

   localparam logic [1:0] OP_ROL = 2'b00;
   localparam logic [1:0] OP_SLL = 2'b01;
   localparam logic [1:0] OP_ROR = 2'b10;
   localparam logic [1:0] OP_SRL = 2'b11;

   function automatic logic [WIDTH-1:0] shift_stage(input logic [WIDTH-1:0] d,
                                                    input logic [1:0]       op,
                                                    input int               amt);
      logic [WIDTH-1:0] r;
      case (op)
         OP_ROL:  r = (d << amt) | (d >> (WIDTH - amt));
         OP_SLL:  r = d << amt;
         OP_ROR:  r = (d >> amt) | (d << (WIDTH - amt));
         default: r = d >> amt;
      endcase
      return r;
   endfunction

   logic [WIDTH-1:0]  data_q [STAGES];
   logic [WIDTH-1:0]  data_d [STAGES];
   logic [WIDTH-1:0]  data_in [STAGES];
   logic [WIDTH-1:0]  res [STAGES];
   logic [1:0]        op_q [STAGES-1];
   logic [1:0]        op_d [STAGES-1];
   logic [1:0]        op_in [STAGES];
   logic [STAGES-1:0] cnt_q [STAGES-1];
   logic [STAGES-1:0] cnt_d [STAGES-1];
   logic [STAGES-1:0] cnt_in [STAGES];
   logic [STAGES-1:0] vld_q, vld_d, vld_in;
   logic              adv;

   // Stage k shifts by 2^k when Cnt[k] is set; the whole pipe advances together or holds.
   always_comb begin
      adv        = !vld_q[STAGES-1] | out_ready;
      data_in[0] = In;
      op_in[0]   = Op;
      cnt_in[0]  = Cnt;
      vld_in[0]  = in_valid;
      for (int k = 1; k < STAGES; k++) begin
         data_in[k] = data_q[k-1];
         op_in[k]   = op_q[k-1];
         cnt_in[k]  = cnt_q[k-1];
         vld_in[k]  = vld_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         res[k]    = cnt_in[k][k] ? shift_stage(data_in[k], op_in[k], 1 << k) : data_in[k];
         data_d[k] = adv ? res[k] : data_q[k];
         vld_d[k]  = !flush && (adv ? vld_in[k] : vld_q[k]);
      end
      for (int k = 0; k < STAGES-1; k++) begin
         op_d[k]  = adv ? op_in[k] : op_q[k];
         cnt_d[k] = adv ? cnt_in[k] : cnt_q[k];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
         for (int k = 0; k < STAGES; k++) data_q[k] <= '0;
         for (int k = 0; k < STAGES-1; k++) begin
            op_q[k]  <= '0;
            cnt_q[k] <= '0;
         end
      end else begin
         vld_q  <= vld_d;
         data_q <= data_d;
         op_q   <= op_d;
         cnt_q  <= cnt_d;
      end
   end

   assign in_ready  = adv;
   assign Out       = data_q[STAGES-1];
   assign out_valid = vld_q[STAGES-1];

`ifdef SHIFT_PIPE_FLAGS_EN
   logic [STAGES-1:0] cy_q, cy_d, cy_in;
   logic              zero_q, zero_d;
   logic              s_cy;
   logic [WIDTH-1:0]  tmp;

   // Logical shifts keep the last bit pushed out; rotates take the bit that wrapped last.
   always_comb begin
      cy_in[0] = 1'b0;
      s_cy     = 1'b0;
      tmp      = '0;
      for (int k = 1; k < STAGES; k++) cy_in[k] = cy_q[k-1];
      for (int k = 0; k < STAGES; k++) begin
         s_cy = cy_in[k];
         tmp  = '0;
         if (cnt_in[k][k] && op_in[k] == OP_SLL) begin
            tmp  = data_in[k] >> (WIDTH - (1 << k));
            s_cy = tmp[0];
         end else if (cnt_in[k][k] && op_in[k] == OP_SRL) begin
            tmp  = data_in[k] >> ((1 << k) - 1);
            s_cy = tmp[0];
         end
         if (k == STAGES-1 && !op_in[k][0])
            s_cy = (cnt_in[k] == '0) ? 1'b0 : (op_in[k][1] ? res[k][WIDTH-1] : res[k][0]);
         cy_d[k] = adv ? s_cy : cy_q[k];
      end
      zero_d = (data_d[STAGES-1] == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cy_q   <= '0;
         zero_q <= 1'b0;
      end else begin
         cy_q   <= cy_d;
         zero_q <= zero_d;
      end
   end

   assign zero = zero_q;
   assign cout = cy_q[STAGES-1];
`endif

endmodule

// File: tb/tb_shift_pipe.sv
// Directed bench for shift_pipe: expected results are queued on accept and checked on output handshake.
module tb_shift_pipe;

   logic        clk;
   logic        rst;
   logic [15:0] In;
   logic [1:0]  Op;
   logic [3:0]  Cnt;
   logic        in_valid;
   logic        in_ready;
   logic        flush;
   logic [15:0] Out;
   logic        out_valid;
   logic        out_ready;
`ifdef SHIFT_PIPE_FLAGS_EN
   logic        zero;
   logic        cout;
`endif

   typedef struct {
      logic [15:0] d;
      logic        z;
      logic        c;
      int          cyc;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   tests = 0;
   int   fails = 0;
   int   npop  = 0;
   int   cyc   = 0;
   bit   chk_lat = 0;

   shift_pipe #(.WIDTH(16), .STAGES(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .In        (In),
      .Op        (Op),
      .Cnt       (Cnt),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .flush     (flush),
      .Out       (Out),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef SHIFT_PIPE_FLAGS_EN
      ,
      .zero      (zero),
      .cout      (cout)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: whole-word shift of a doubled operand.
   function automatic exp_t mk(input logic [15:0] d, input logic [1:0] op, input logic [3:0] c, input int t);
      exp_t        e;
      logic [31:0] w;
      logic [15:0] r;
      logic        cb;
      case (op)
         2'b00: begin w = {d, d} << c; r = w[31:16]; cb = (c != 0) ? r[0] : 1'b0; end
         2'b01: begin r = d << c; w = {16'h0, d} << c; cb = (c != 0) ? w[16] : 1'b0; end
         2'b10: begin w = {d, d} >> c; r = w[15:0]; cb = (c != 0) ? r[15] : 1'b0; end
         default: begin r = d >> c; w = {d, 16'h0} >> c; cb = (c != 0) ? w[15] : 1'b0; end
      endcase
      e.d   = r;
      e.z   = (r == 16'h0);
      e.c   = cb;
      e.cyc = t;
      return e;
   endfunction

   always @(negedge clk) begin
      if (out_valid && out_ready && !rst) begin
         if (q.size() == 0) begin
            chk("spurious_out", 32'(out_valid), 0);
         end else begin
            mon_e = q.pop_front();
            npop++;
            chk("out_data", 32'(Out), 32'(mon_e.d));
            if (chk_lat) chk("latency", cyc - mon_e.cyc, 4);
`ifdef SHIFT_PIPE_FLAGS_EN
            chk("flag_zero", 32'(zero), 32'(mon_e.z));
            chk("flag_cout", 32'(cout), 32'(mon_e.c));
`endif
         end
      end
      if (rst || flush) q.delete();
      else if (in_valid && in_ready) q.push_back(mk(In, Op, Cnt, cyc));
   end

   task automatic send(input logic [15:0] d, input logic [1:0] op, input logic [3:0] c);
      bit acc;
      acc      = 1'b0;
      In       = d;
      Op       = op;
      Cnt      = c;
      in_valid = 1'b1;
      for (int i = 0; i < 40 && !acc; i++) begin
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!acc) chk("send_timeout", 32'(acc), 1);
   endtask

   task automatic wait_drain(input string tag);
      int n;
      n = 0;
      while (q.size() != 0 && n < 64) begin
         @(posedge clk);
         #2;
         n++;
      end
      chk(tag, q.size(), 0);
   endtask

   task automatic quiet(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         chk(tag, 32'(out_valid), 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int          n0;
      logic [15:0] held;
      rst       = 1'b1;
      In        = '0;
      Op        = '0;
      Cnt       = '0;
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset_out_valid", 32'(out_valid), 0);
      chk("reset_out", 32'(Out), 0);
      chk("reset_in_ready", 32'(in_ready), 1);

      // Single rotate-left: 4-cycle latency and a one-cycle valid pulse.
      chk_lat = 1'b1;
      send(16'h8001, 2'b00, 4'd1);
      wait_drain("rol_drain");
      chk("rol_pulse", 32'(out_valid), 0);

      // Directed operands including the Cnt=0 and Cnt=15 boundaries.
      send(16'h8000, 2'b11, 4'd15);
      send(16'hFFFF, 2'b01, 4'd4);
      send(16'h1234, 2'b10, 4'd4);
      send(16'h1234, 2'b00, 4'd0);
      send(16'h0001, 2'b01, 4'd15);
      send(16'hBEEF, 2'b11, 4'd0);
      send(16'h8001, 2'b10, 4'd15);
      wait_drain("directed_drain");

      // Back-to-back random stream.
      n0 = npop;
      for (int i = 0; i < 8; i++)
         send(16'($urandom()), 2'($urandom_range(3, 0)), 4'($urandom_range(15, 0)));
      wait_drain("stream_drain");
      chk("stream_count", npop - n0, 8);

      // Fill then stall the consumer.
      chk_lat   = 1'b0;
      out_ready = 1'b0;
      n0        = npop;
      send(16'hA5C3, 2'b00, 4'd3);
      send(16'h0F0F, 2'b11, 4'd2);
      send(16'hFFFF, 2'b01, 4'd15);
      send(16'h8001, 2'b10, 4'd1);
      chk("stall_in_ready", 32'(in_ready), 0);
      chk("stall_out_valid", 32'(out_valid), 1);
      chk("stall_head", 32'(Out), 32'(q[0].d));
      held     = Out;
      In       = 16'h7777;
      Op       = 2'b01;
      Cnt      = 4'd1;
      in_valid = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("stall_hold", 32'(Out), 32'(held));
         chk("stall_in_ready_hold", 32'(in_ready), 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      wait_drain("stall_drain");
      chk("stall_count", npop - n0, 4);
      chk_lat = 1'b1;

      // Flush with three in flight and a coincident input.
      send(16'h1111, 2'b00, 4'd1);
      send(16'h2222, 2'b01, 4'd2);
      send(16'h3333, 2'b10, 4'd3);
      flush    = 1'b1;
      In       = 16'h4444;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush_out_valid", 32'(out_valid), 0);
      quiet("flush_quiet", 8);
      send(16'h00F0, 2'b01, 4'd8);
      wait_drain("post_flush_drain");

      // Reset with three in flight.
      send(16'h5555, 2'b00, 4'd5);
      send(16'h6666, 2'b11, 4'd6);
      send(16'h7777, 2'b10, 4'd7);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out", 32'(Out), 0);
      chk("rst_in_ready", 32'(in_ready), 1);
      quiet("rst_quiet", 8);

`ifdef SHIFT_PIPE_FLAGS_EN
      send(16'h8000, 2'b01, 4'd1);
      wait_drain("flags_drain");
      send(16'hC000, 2'b00, 4'd2);
      send(16'h0001, 2'b11, 4'd1);
      wait_drain("flags_rot_drain");
`endif

      send(16'h8001, 2'b00, 4'd1);
      wait_drain("final_drain");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
